// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around ram_port_arbiter.
// The arbiter takes the slave view; the requesters/RAM model take master.
interface ram_port_arbiter_if;
    // Instruction-fetch port (read-only)
    logic        if_req_in;
    logic [63:0] if_address_in;
    logic        if_ack_out;
    logic [63:0] if_data_out;
    logic        if_err_out;

    // Load/store port
    logic        d_req_in;
    logic [63:0] d_address_in;
    logic [7:0]  d_write_mask_in;
    logic [63:0] d_write_value_in;
    logic        d_ack_out;
    logic [63:0] d_data_out;
    logic        d_err_out;

    // Single-port RAM side
    logic [63:0] ram_address_out;
    logic        ram_sel_out;
    logic [7:0]  ram_write_mask_out;
    logic [63:0] ram_write_value_out;
    logic [63:0] ram_read_value_in;

    modport slave (
        input  if_req_in, if_address_in,
        output if_ack_out, if_data_out, if_err_out,
        input  d_req_in, d_address_in, d_write_mask_in, d_write_value_in,
        output d_ack_out, d_data_out, d_err_out,
        output ram_address_out, ram_sel_out, ram_write_mask_out, ram_write_value_out,
        input  ram_read_value_in
    );

    modport master (
        output if_req_in, if_address_in,
        input  if_ack_out, if_data_out, if_err_out,
        output d_req_in, d_address_in, d_write_mask_in, d_write_value_in,
        input  d_ack_out, d_data_out, d_err_out,
        input  ram_address_out, ram_sel_out, ram_write_mask_out, ram_write_value_out,
        output ram_read_value_in
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch (read-only) and the
// load/store unit. One access at a time: IDLE -> ISSUE -> DONE, with the RAM
// doing its work at the negedge inside ISSUE. Data port has priority, but
// only for STARVE_LIMIT back-to-back grants while fetch is waiting.
// Out-of-range addresses skip ISSUE and are acked with an error.
module ram_port_arbiter #(
    parameter longint unsigned MEM_BYTES    = 65536,
    parameter int unsigned     STARVE_LIMIT = 2
) (
    input logic              clk,
    input logic              reset,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT     = SW'(STARVE_LIMIT);
    localparam logic [63:0]   MEM_LIMIT = 64'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;     // 0 = fetch, 1 = data
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [63:0]   addr_q, addr_d;
    logic [7:0]    mask_q, mask_d;
    logic [63:0]   wval_q, wval_d;
    logic [63:0]   if_data_q, if_data_d;
    logic [63:0]   d_data_q, d_data_d;

    // Arbitration inputs for the IDLE decision
    logic        pick_data;
    logic [63:0] sel_addr;

    // Data wins a tie only while fetch has not yet waited STARVE_LIMIT grants
    always_comb begin
        pick_data = bus.d_req_in && (!bus.if_req_in || (starve_q < LIMIT));
        sel_addr  = pick_data ? bus.d_address_in : bus.if_address_in;
    end

    // Next-state and datapath latching
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        err_d     = err_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wval_d    = wval_q;
        if_data_d = if_data_q;
        d_data_d  = d_data_q;

        case (state_q)
            IDLE: begin
                if (bus.if_req_in || bus.d_req_in) begin
                    grant_d = pick_data;
                    addr_d  = sel_addr;
                    if (pick_data) begin
                        mask_d = bus.d_write_mask_in;
                        wval_d = bus.d_write_value_in;
                        // Count grants that made fetch wait; saturate at the limit
                        if (bus.if_req_in)
                            starve_d = (starve_q < LIMIT) ? starve_q + SW'(1) : starve_q;
                        else
                            starve_d = '0;
                    end else begin
                        // Fetch never writes
                        mask_d   = '0;
                        wval_d   = '0;
                        starve_d = '0;
                    end

                    if (sel_addr < MEM_LIMIT) begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        // Rejected without a RAM cycle; the port sees data 0
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (pick_data) d_data_d  = '0;
                        else           if_data_d = '0;
                    end
                end
            end

            ISSUE: begin
                // RAM has produced its word at the negedge inside ISSUE
                if (grant_q) d_data_d  = bus.ram_read_value_in;
                else         if_data_d = bus.ram_read_value_in;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            err_q     <= 1'b0;
            starve_q  <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            wval_q    <= '0;
            if_data_q <= '0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wval_q    <= wval_d;
            if_data_q <= if_data_d;
            d_data_q  <= d_data_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.ram_sel_out         = (state_q == ISSUE);
        bus.ram_write_mask_out  = (state_q == ISSUE) ? mask_q : 8'h00;
        bus.ram_address_out     = addr_q;
        bus.ram_write_value_out = wval_q;

        bus.if_ack_out  = (state_q == DONE) && !grant_q;
        bus.d_ack_out   = (state_q == DONE) &&  grant_q;
        bus.if_err_out  = (state_q == DONE) && !grant_q && err_q;
        bus.d_err_out   = (state_q == DONE) &&  grant_q && err_q;
        bus.if_data_out = if_data_q;
        bus.d_data_out  = d_data_q;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter. Two instances share clock/reset
// and a small RAM model: dut (STARVE_LIMIT=2) and dut0 (STARVE_LIMIT=0).
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_port_arbiter_if m ();
    ram_port_arbiter_if m0 ();

    ram_port_arbiter #(.MEM_BYTES(65536), .STARVE_LIMIT(2)) dut  (.clk(clk), .reset(reset), .bus(m.slave));
    ram_port_arbiter #(.MEM_BYTES(65536), .STARVE_LIMIT(0)) dut0 (.clk(clk), .reset(reset), .bus(m0.slave));

    typedef struct {
        bit          dport;
        logic [63:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t sb0[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    logic [63:0] mem [128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // RAM model: reads the old word, then applies the byte-masked write, at the negedge
    always @(negedge clk) begin
        if (m.ram_sel_out) begin
            m.ram_read_value_in <= mem[m.ram_address_out[9:3]];
            for (int b = 0; b < 8; b++)
                if (m.ram_write_mask_out[b])
                    mem[m.ram_address_out[9:3]][8*b +: 8] = m.ram_write_value_out[8*b +: 8];
        end
        if (m0.ram_sel_out)
            m0.ram_read_value_in <= mem[m0.ram_address_out[9:3]];
    end

    // Monitor for dut
    always @(negedge clk) begin
        if (m.if_ack_out || m.d_ack_out) begin
            exp_t e;
            chk("dual_ack", 64'(m.if_ack_out & m.d_ack_out), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 64'(m.d_ack_out), 64'(e.dport));
                chk("ack_data", e.dport ? m.d_data_out : m.if_data_out, e.data);
                chk("ack_err", 64'(e.dport ? m.d_err_out : m.if_err_out), 64'(e.err));
            end
        end
    end

    // Monitor for dut0
    always @(negedge clk) begin
        if (m0.if_ack_out || m0.d_ack_out) begin
            exp_t e;
            chk("dual_ack0", 64'(m0.if_ack_out & m0.d_ack_out), 64'd0);
            if (sb0.size() == 0) begin
                chk("unexpected_ack0", 64'd1, 64'd0);
            end else begin
                e = sb0.pop_front();
                chk("ack_port0", 64'(m0.d_ack_out), 64'(e.dport));
                chk("ack_data0", e.dport ? m0.d_data_out : m0.if_data_out, e.data);
                chk("ack_err0", 64'(e.dport ? m0.d_err_out : m0.if_err_out), 64'(e.err));
            end
        end
    end

    // Wait for any ack on one instance, bounded
    task automatic wait_ack(input bit on0, input int budget, output int n, output bit dack);
        bit seen;
        n = 0; seen = 0; dack = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (on0) begin seen = m0.if_ack_out | m0.d_ack_out; dack = m0.d_ack_out; end
            else     begin seen = m.if_ack_out  | m.d_ack_out;  dack = m.d_ack_out;  end
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL ack_timeout: no ack within %0d cycles", budget);
        end
    endtask

    initial begin
        int          n;
        bit          dack, got, flag;
        int          t_prev, t_now;
        logic [5:0]  pat;
        logic [63:0] w5;

        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[8]  = 64'h0101_0101_0101_0101;   // 0x40
        mem[16] = 64'hDEAD_BEEF_CAFE_F00D;   // 0x80

        reset = 1'b1;
        m.if_req_in = 0;  m.if_address_in = '0;
        m.d_req_in = 0;   m.d_address_in = '0; m.d_write_mask_in = '0; m.d_write_value_in = '0;
        m0.if_req_in = 0; m0.if_address_in = '0;
        m0.d_req_in = 0;  m0.d_address_in = '0; m0.d_write_mask_in = '0; m0.d_write_value_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",   64'(m.ram_sel_out), 64'd0);
        chk("rst_acks",  64'({m.if_ack_out, m.d_ack_out, m.if_err_out, m.d_err_out}), 64'd0);
        chk("rst_addr",  m.ram_address_out, 64'd0);
        chk("rst_ddata", m.d_data_out, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: data write at 0x40, full mask; returns the pre-write word
        sb.push_back('{dport: 1'b1, data: 64'h0101_0101_0101_0101, err: 1'b0});
        m.d_address_in = 64'h40; m.d_write_mask_in = 8'hFF;
        m.d_write_value_in = 64'h1122_3344_5566_7788; m.d_req_in = 1;
        @(negedge clk);
        chk("t1_pre_sel", 64'(m.ram_sel_out), 64'd0);
        @(negedge clk);
        chk("t1_sel",  64'(m.ram_sel_out), 64'd1);
        chk("t1_addr", m.ram_address_out, 64'h40);
        chk("t1_mask", 64'(m.ram_write_mask_out), 64'hFF);
        chk("t1_wval", m.ram_write_value_out, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("t1_ack_lat", 64'(m.d_ack_out), 64'd1);
        @(posedge clk); #1 m.d_req_in = 0;
        @(negedge clk);
        chk("t1_ack_pulse", 64'(m.d_ack_out), 64'd0);
        chk("t1_mem", mem[8], 64'h1122_3344_5566_7788);

        // 2: fetch read at 0x80; no write mask at any point
        sb.push_back('{dport: 1'b0, data: 64'hDEAD_BEEF_CAFE_F00D, err: 1'b0});
        @(posedge clk); #1 m.if_address_in = 64'h80; m.if_req_in = 1;
        n = 0; got = 0; flag = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            if (m.ram_write_mask_out != 8'h00) flag = 1;
            got = m.if_ack_out;
        end
        chk("t2_ack_lat", 64'(n), 64'd3);
        chk("t2_mask_zero", 64'(flag), 64'd0);
        chk("t2_err", 64'(m.if_err_out), 64'd0);
        @(posedge clk); #1 m.if_req_in = 0;

        // 4: out-of-range data read: err ack one cycle after sampling, no RAM access
        sb.push_back('{dport: 1'b1, data: 64'd0, err: 1'b1});
        @(posedge clk); #1 m.d_address_in = 64'h10000; m.d_write_mask_in = 8'h00; m.d_req_in = 1;
        n = 0; got = 0; flag = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            if (m.ram_sel_out) flag = 1;
            got = m.d_ack_out;
        end
        chk("t4_ack_lat", 64'(n), 64'd2);
        chk("t4_d_err", 64'(m.d_err_out), 64'd1);
        chk("t4_no_sel", 64'(flag), 64'd0);
        @(posedge clk); #1 m.d_req_in = 0;

        // 3: both held, STARVE_LIMIT=2 -> D D F D D F, acks 3 cycles apart
        for (int k = 0; k < 6; k++)
            sb.push_back((k % 3 == 2) ? '{dport: 1'b0, data: 64'hDEAD_BEEF_CAFE_F00D, err: 1'b0}
                                      : '{dport: 1'b1, data: 64'h1122_3344_5566_7788, err: 1'b0});
        @(posedge clk); #1
        m.if_address_in = 64'h80; m.d_address_in = 64'h40; m.d_write_mask_in = 8'h00;
        m.if_req_in = 1; m.d_req_in = 1;
        pat = '0; t_prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(1'b0, 10, n, dack);
            pat[k] = dack;
            t_now = cyc;
            if (k > 0) chk("t3_spacing", 64'(t_now - t_prev), 64'd3);
            t_prev = t_now;
        end
        chk("t3_pattern", 64'(pat), 64'b011011);
        @(posedge clk); #1 m.if_req_in = 0; m.d_req_in = 0;
        repeat (2) @(posedge clk);

        // 5: reset during ISSUE of a write: write commits, no ack, outputs cleared
        w5 = 64'hAABB_CCDD_0011_2233;
        @(posedge clk); #1
        m.d_address_in = 64'h100; m.d_write_mask_in = 8'hFF; m.d_write_value_in = w5; m.d_req_in = 1;
        n = 0; got = 0;
        while (!got && n < 10) begin @(negedge clk); n++; got = m.ram_sel_out; end
        chk("t5_sel_issue", 64'(m.ram_sel_out), 64'd1);
        chk("t5_mask_issue", 64'(m.ram_write_mask_out), 64'hFF);
        reset = 1'b1; m.d_req_in = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_sel_after", 64'(m.ram_sel_out), 64'd0);
        chk("t5_mask_after", 64'(m.ram_write_mask_out), 64'd0);
        chk("t5_addr_after", m.ram_address_out, 64'd0);
        chk("t5_wval_after", m.ram_write_value_out, 64'd0);
        chk("t5_ifdata_after", m.if_data_out, 64'd0);
        chk("t5_ddata_after", m.d_data_out, 64'd0);
        chk("t5_acks_after", 64'({m.if_ack_out, m.d_ack_out, m.if_err_out, m.d_err_out}), 64'd0);
        chk("t5_mem_commit", mem[32], w5);
        repeat (4) @(negedge clk);

        // 6: STARVE_LIMIT=0: fetch always wins; data only once fetch drops
        for (int k = 0; k < 3; k++)
            sb0.push_back('{dport: 1'b0, data: 64'hDEAD_BEEF_CAFE_F00D, err: 1'b0});
        sb0.push_back('{dport: 1'b1, data: 64'h1122_3344_5566_7788, err: 1'b0});
        @(posedge clk); #1
        m0.if_address_in = 64'h80; m0.d_address_in = 64'h40; m0.d_write_mask_in = 8'h00;
        m0.if_req_in = 1; m0.d_req_in = 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, 10, n, dack);
            chk("t6_fetch_wins", 64'(dack), 64'd0);
        end
        @(posedge clk); #1 m0.if_req_in = 0;
        wait_ack(1'b1, 10, n, dack);
        chk("t6_data_after", 64'(dack), 64'd1);
        @(posedge clk); #1 m0.d_req_in = 0;
        repeat (4) @(posedge clk);

        chk("sb_drain",  64'(sb.size()),  64'd0);
        chk("sb0_drain", 64'(sb0.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #20000;
        $display("FAIL global_timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end
endmodule
